mult_4bits_seq: RTL and testbench

- Sequential shift-and-add multiplier.
- Directly downstream of the Avalon-MM dual-port-RAM bridge, which supplies A, B and a level enable, then waits on fim to store Y.
- Captures operands on the first enable cycle and computes one partial product per clock.
- Holds the result and fim until the bridge drops enable.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/mult_4bits_seq_controller.sv | 112 +++++++++++
 rtl/mult_4bits_seq.sv | 113 +++++++++++
 tb/tb_mult_4bits_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared types and constants for the sequential shift-and-add multiplier.
//
//   Contents:
//     mult_estado_t        FSM state encoding (exposed on state_o for test)
//     MULT_N_BITS_DEFAULT  default operand width
//     mult_cnt_width()     width of the iteration counter for a given N_BITS
//     mult_is_last()       true on the final partial-product iteration
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int unsigned MULT_N_BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_MULT_IDLE = 2'd0,
        ST_MULT_CALC = 2'd1,
        ST_MULT_FIM  = 2'd2
    } mult_estado_t;

    // The counter runs 0 .. N_BITS-1, so it needs clog2(N_BITS) bits
    // (at least one).
    function automatic int unsigned mult_cnt_width(input int unsigned n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

    // The iteration with cnt == N_BITS-1 consumes the last multiplier bit.
    function automatic logic mult_is_last(input int unsigned cnt,
                                          input int unsigned n_bits);
        return (cnt == (n_bits - 1));
    endfunction

endpackage : mult_pkg

// File: rtl/mult_4bits_seq_controller.sv
// -----------------------------------------------------------------------------
// mult_4bits_seq_controller
//   Control FSM and iteration counter for mult_4bits_seq.
//
//   Ports:
//     clk_i     in   system clock, rising edge
//     rst_i     in   asynchronous active-high reset
//     enable_i  in   level request from the bridge
//     last_i    in   current iteration is the final one (decoded from cnt_o)
//     state_o   out  registered FSM state
//     cnt_o     out  iteration counter (0 .. N_BITS-1)
//     load_o    out  capture strobe: latch operands, clear counter
//     step_o    out  iterate strobe: advance partial product and counter
//     done_o    out  final-iteration strobe: load the product register
//
//   Sequence: IDLE --enable--> CALC (N_BITS edges) --> FIM --!enable--> IDLE.
//   Dropping enable_i in CALC aborts to IDLE without producing a result.
// -----------------------------------------------------------------------------
module mult_4bits_seq_controller
    import mult_pkg::*;
#(
    parameter int unsigned N_BITS = MULT_N_BITS_DEFAULT,
    parameter int unsigned CNT_W  = mult_cnt_width(N_BITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             last_i,
    output mult_estado_t     state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             load_o,
    output logic             step_o,
    output logic             done_o
);

    mult_estado_t     state_q;
    mult_estado_t     state_d;
    logic [CNT_W-1:0] cnt_q;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_MULT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and strobe decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            ST_MULT_IDLE: begin
                if (enable_i) begin
                    load_o  = 1'b1;
                    state_d = ST_MULT_CALC;
                end
            end

            ST_MULT_CALC: begin
                // Abort wins over iterating: the bridge withdrew its request,
                // so the partial product is simply abandoned.
                if (!enable_i) begin
                    state_d = ST_MULT_IDLE;
                end else begin
                    step_o = 1'b1;
                    if (last_i) begin
                        done_o  = 1'b1;
                        state_d = ST_MULT_FIM;
                    end
                end
            end

            ST_MULT_FIM: begin
                // Holding enable_i high here never restarts; a fresh request
                // must pass through IDLE with enable_i low first.
                if (!enable_i) begin
                    state_d = ST_MULT_IDLE;
                end
            end

            default: begin
                state_d = ST_MULT_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Iteration counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_o) begin
            cnt_q <= '0;
        end else if (step_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;

endmodule : mult_4bits_seq_controller

// File: rtl/mult_4bits_seq.sv
// -----------------------------------------------------------------------------
// mult_4bits_seq
//   Sequential shift-and-add multiplier, one partial product per clock.
//   Sits directly behind the Avalon-MM dual-port-RAM bridge.
//
//   Ports:
//     clk_i     in   system clock, rising edge
//     rst_i     in   asynchronous active-high reset
//     A_i       in   multiplicand, sampled only at the capture edge
//     B_i       in   multiplier, sampled only at the capture edge
//     enable_i  in   level request from the bridge
//     Y_o       out  registered product (2*N_BITS)
//     fim_o     out  result valid / operation complete
//     state_o   out  current FSM state (test visibility)
//
//   Handshake: enable_i is a level request and fim_o the level acknowledge.
//   The bridge raises enable_i with A_i/B_i valid for the capture edge only,
//   keeps enable_i high until it has stored Y_o, then drops it. fim_o rises
//   exactly N_BITS edges after capture and falls one edge after enable_i
//   falls. Y_o changes only on entry to FIM, so it is stable whenever the
//   bridge may sample it. Dropping enable_i before fim_o aborts the operation.
//
//   N_BITS must be at least 2.
// -----------------------------------------------------------------------------
module mult_4bits_seq
    import mult_pkg::*;
#(
    parameter int unsigned N_BITS = MULT_N_BITS_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_BITS-1:0]     A_i,
    input  logic [N_BITS-1:0]     B_i,
    input  logic                  enable_i,
    output logic [2*N_BITS-1:0]   Y_o,
    output logic                  fim_o,
    output mult_estado_t          state_o
);

    localparam int unsigned CNT_W = mult_cnt_width(N_BITS);

    // Datapath registers
    logic [N_BITS-1:0]   mcand_q;
    logic [2*N_BITS-1:0] p_q;
    logic [2*N_BITS-1:0] y_q;

    // Controller interface
    mult_estado_t        state;
    logic [CNT_W-1:0]    cnt;
    logic                last;
    logic                load;
    logic                step;
    logic                done;

    // Iteration datapath
    logic [N_BITS:0]     sum;
    logic [2*N_BITS-1:0] p_step;

    assign last = mult_is_last(32'(cnt), N_BITS);

    mult_4bits_seq_controller #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_controller (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .last_i   (last),
        .state_o  (state),
        .cnt_o    (cnt),
        .load_o   (load),
        .step_o   (step),
        .done_o   (done)
    );

    // ---------------------------------------------------------------------
    // One shift-and-add iteration. P holds {accumulator, remaining
    // multiplier bits}; the low bit of P decides whether the multiplicand
    // is added. The N_BITS+1-bit sum keeps the adder carry, which lands in
    // P's MSB after the right shift, so the 2*N_BITS product never overflows.
    // ---------------------------------------------------------------------
    always_comb begin
        sum    = {1'b0, p_q[2*N_BITS-1:N_BITS]}
               + (p_q[0] ? {1'b0, mcand_q} : '0);
        p_step = {sum, p_q[N_BITS-1:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            p_q     <= '0;
            y_q     <= '0;
        end else begin
            if (load) begin
                mcand_q <= A_i;
                p_q     <= {{N_BITS{1'b0}}, B_i};
            end else if (step) begin
                p_q     <= p_step;
            end

            // The final iteration's result goes straight into Y so that Y
            // and fim_o become valid on the same edge.
            if (done) begin
                y_q <= p_step;
            end
        end
    end

    assign Y_o     = y_q;
    assign fim_o   = (state == ST_MULT_FIM);
    assign state_o = state;

endmodule : mult_4bits_seq

// File: tb/tb_mult_4bits_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_4bits_seq
//   Self-checking bench for mult_4bits_seq (N_BITS = 4).
//   Expected products come from plain integer multiplication; expected
//   latency is the fixed N_BITS edges from capture to fim_o.
// -----------------------------------------------------------------------------
module tb_mult_4bits_seq;
    import mult_pkg::*;

    localparam int N        = 4;
    localparam int LAT      = N;
    localparam int MAX_WAIT = 20;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] y;
    logic         fim;
    mult_estado_t state;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] exp_q[$];

    always #5 clk = ~clk;

    mult_4bits_seq #(.N_BITS(N)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .A_i      (a),
        .B_i      (b),
        .enable_i (enable),
        .Y_o      (y),
        .fim_o    (fim),
        .state_o  (state)
    );

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [2*N-1:0] ref_product(input int unsigned x,
                                                   input int unsigned z);
        int unsigned p;
        p = x * z;
        return p[2*N-1:0];
    endfunction

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Present operands for exactly the capture edge, then scramble them.
    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] z);
        a      = x;
        b      = z;
        enable = 1'b1;
        step_clk();
        a = N'($urandom_range(0, (1 << N) - 1));
        b = N'($urandom_range(0, (1 << N) - 1));
    endtask

    // Edges from capture until fim_o is seen; -1 when the budget expires.
    task automatic wait_fim(output int lat);
        lat = 0;
        while (lat < MAX_WAIT) begin
            step_clk();
            lat++;
            if (fim === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic release_enable();
        enable = 1'b0;
        step_clk();
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        int lat;
        rst = 1'b1; enable = 1'b0; a = '0; b = '0;
        repeat (3) step_clk();
        checks++; if (state !== ST_MULT_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_MULT_IDLE); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", y); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_fim: got %b expected 0", fim); end
        rst = 1'b0;
        step_clk();

        // Leave a nonzero product behind so the mid-CALC reset visibly clears it.
        start_op(4'd2, 4'd3);
        wait_fim(lat);
        release_enable();
        checks++; if (y !== ref_product(2, 3)) begin errors++; $display("FAIL reset_preload_y: got %h expected %h", y, ref_product(2, 3)); end

        start_op(4'd9, 4'd7);
        step_clk();
        checks++; if (state !== ST_MULT_CALC) begin errors++; $display("FAIL reset_midcalc_state: got %0d expected %0d", state, ST_MULT_CALC); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== ST_MULT_IDLE) begin errors++; $display("FAIL reset_async_state: got %0d expected %0d", state, ST_MULT_IDLE); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_async_y: got %h expected 00", y); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_async_fim: got %b expected 0", fim); end
        enable = 1'b0;
        repeat (2) step_clk();
        rst = 1'b0;
        repeat (3) step_clk();
        checks++; if (state !== ST_MULT_IDLE) begin errors++; $display("FAIL reset_release_idle: got %0d expected %0d", state, ST_MULT_IDLE); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_release_fim: got %b expected 0", fim); end
    endtask

    task automatic test_basic();
        int lat;
        start_op(4'd3, 4'd5);
        wait_fim(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (y !== 8'h0F) begin errors++; $display("FAIL basic_y: got %h expected 0f", y); end
        checks++; if (state !== ST_MULT_FIM) begin errors++; $display("FAIL basic_state: got %0d expected %0d", state, ST_MULT_FIM); end
        release_enable();
    endtask

    task automatic test_extremes();
        int lat;
        int unsigned ea[3] = '{15, 0, 8};
        int unsigned eb[3] = '{15, 13, 1};
        logic [2*N-1:0] ey[3] = '{8'hE1, 8'h00, 8'h08};
        for (int i = 0; i < 3; i++) begin
            start_op(N'(ea[i]), N'(eb[i]));
            wait_fim(lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL extreme_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (y !== ey[i]) begin errors++; $display("FAIL extreme_y[%0d]: got %h expected %h", i, y, ey[i]); end
            release_enable();
        end
    endtask

    task automatic test_hold_release();
        int lat;
        logic [2*N-1:0] exp;
        exp = ref_product(11, 13);
        start_op(4'd11, 4'd13);
        wait_fim(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (y !== exp) begin errors++; $display("FAIL hold_y: got %h expected %h", y, exp); end
        for (int i = 0; i < 10; i++) begin
            step_clk();
            checks++;
            if (fim !== 1'b1 || y !== exp || state !== ST_MULT_FIM) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got fim=%b y=%h state=%0d expected fim=1 y=%h state=%0d",
                         i, fim, y, state, exp, ST_MULT_FIM);
            end
        end
        release_enable();
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL release_fim: got %b expected 0", fim); end
        checks++; if (y !== exp) begin errors++; $display("FAIL release_y: got %h expected %h", y, exp); end
        checks++; if (state !== ST_MULT_IDLE) begin errors++; $display("FAIL release_state: got %0d expected %0d", state, ST_MULT_IDLE); end
    endtask

    task automatic test_abort();
        int lat;
        logic fim_seen;
        logic [2*N-1:0] prior;
        prior = ref_product(11, 13);
        start_op(4'd6, 4'd6);
        step_clk();
        enable = 1'b0;
        step_clk();
        checks++; if (state !== ST_MULT_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", state, ST_MULT_IDLE); end
        fim_seen = fim;
        repeat (8) begin
            step_clk();
            if (fim !== 1'b0) fim_seen = 1'b1;
        end
        checks++; if (fim_seen !== 1'b0) begin errors++; $display("FAIL abort_fim: got %b expected 0", fim_seen); end
        checks++; if (y !== prior) begin errors++; $display("FAIL abort_y_kept: got %h expected %h", y, prior); end
        start_op(4'd6, 4'd6);
        wait_fim(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (y !== 8'h24) begin errors++; $display("FAIL abort_next_y: got %h expected 24", y); end
        release_enable();
    endtask

    task automatic test_back_to_back();
        int lat;
        int h;
        int width;
        int unsigned x;
        int unsigned z;
        logic [2*N-1:0] exp;
        for (int i = 0; i < 50; i++) begin
            x = $urandom_range(0, (1 << N) - 1);
            z = $urandom_range(0, (1 << N) - 1);
            exp_q.push_back(ref_product(x, z));
            start_op(N'(x), N'(z));
            wait_fim(lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            exp = exp_q.pop_front();
            checks++; if (y !== exp) begin errors++; $display("FAIL b2b_y[%0d]: got %h expected %h (a=%0d b=%0d)", i, y, exp, x, z); end
            h = $urandom_range(0, 4);
            width = (fim === 1'b1) ? 1 : 0;
            repeat (h) begin
                step_clk();
                if (fim === 1'b1) width++;
            end
            release_enable();
            checks++; if (fim !== 1'b0) begin errors++; $display("FAIL b2b_fim_drop[%0d]: got %b expected 0", i, fim); end
            checks++; if (width !== h + 1) begin errors++; $display("FAIL b2b_fim_width[%0d]: got %0d expected %0d", i, width, h + 1); end
        end
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_hold_release();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule : tb_mult_4bits_seq
